// File: rtl/scan_test_controller.sv
// Scan test sequencer: shift-in, single capture, shift-out, parallel response.
// Optional SCAN_COMPARE_EN adds EXPECTED input and registered PASS output.
module scan_test_controller #(
   parameter int   CHAIN_LEN = 4,
   parameter logic SI_FILL   = 1'b0
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 start,
   input  logic                 abort,
   input  logic [CHAIN_LEN-1:0] pattern,
`ifdef SCAN_COMPARE_EN
   input  logic [CHAIN_LEN-1:0] expected,
   output logic                 pass,
`endif
   input  logic                 so,
   output logic                 se,
   output logic                 si,
   output logic                 busy,
   output logic                 done,
   output logic [CHAIN_LEN-1:0] response
);

   localparam int             CW       = $clog2(CHAIN_LEN + 1);
   localparam logic [CW-1:0]  CNT_LOAD = CW'(CHAIN_LEN - 1);
   localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
   localparam logic [CW-1:0]  CNT_ZERO = CW'(0);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SHIFT_IN  = 2'd1,
      CAPTURE   = 2'd2,
      SHIFT_OUT = 2'd3
   } state_t;

   state_t               state_r, state_s;
   logic [CW-1:0]        cnt_r, cnt_s;
   logic [CHAIN_LEN-1:0] pat_r, pat_s;
   logic [CHAIN_LEN-1:0] sh_r, sh_s;
   logic [CHAIN_LEN-1:0] resp_r, resp_s;
   logic                 se_r, se_s;
   logic                 si_r, si_s;
   logic                 busy_r, busy_s;
   logic                 done_r, done_s;
`ifdef SCAN_COMPARE_EN
   logic [CHAIN_LEN-1:0] exp_r, exp_s;
   logic                 pass_r, pass_s;
`endif

   // Next-state and next-output logic for the test sequence.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      pat_s   = pat_r;
      sh_s    = sh_r;
      resp_s  = resp_r;
      se_s    = se_r;
      si_s    = si_r;
      busy_s  = busy_r;
      done_s  = 1'b0;
`ifdef SCAN_COMPARE_EN
      exp_s   = exp_r;
      pass_s  = pass_r;
`endif
      if (abort) begin
         state_s = IDLE;
         cnt_s   = CNT_ZERO;
         se_s    = 1'b0;
         si_s    = SI_FILL;
         busy_s  = 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  state_s = SHIFT_IN;
                  cnt_s   = CNT_LOAD;
                  se_s    = 1'b1;
                  si_s    = pattern[CHAIN_LEN-1];
                  pat_s   = pattern << 1'b1;
                  busy_s  = 1'b1;
`ifdef SCAN_COMPARE_EN
                  exp_s   = expected;
`endif
               end else begin
                  se_s   = 1'b0;
                  si_s   = SI_FILL;
                  busy_s = 1'b0;
               end
            end
            SHIFT_IN: begin
               if (cnt_r == CNT_ZERO) begin
                  state_s = CAPTURE;
                  se_s    = 1'b0;
                  si_s    = SI_FILL;
               end else begin
                  cnt_s = cnt_r - CNT_ONE;
                  si_s  = pat_r[CHAIN_LEN-1];
                  pat_s = pat_r << 1'b1;
               end
            end
            CAPTURE: begin
               state_s = SHIFT_OUT;
               cnt_s   = CNT_LOAD;
               se_s    = 1'b1;
               si_s    = SI_FILL;
            end
            SHIFT_OUT: begin
               // The counter value equals the response bit index being sampled.
               for (int k = 0; k < CHAIN_LEN; k++) begin
                  sh_s[k] = (cnt_r == CW'(k)) ? so : sh_r[k];
               end
               if (cnt_r == CNT_ZERO) begin
                  state_s = IDLE;
                  se_s    = 1'b0;
                  si_s    = SI_FILL;
                  busy_s  = 1'b0;
                  done_s  = 1'b1;
                  resp_s  = sh_s;
`ifdef SCAN_COMPARE_EN
                  pass_s  = (sh_s == exp_r) ? 1'b1 : 1'b0;
`endif
               end else begin
                  cnt_s = cnt_r - CNT_ONE;
               end
            end
            default: begin
               state_s = IDLE;
               cnt_s   = CNT_ZERO;
               se_s    = 1'b0;
               si_s    = SI_FILL;
               busy_s  = 1'b0;
            end
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r <= IDLE;
         cnt_r   <= CNT_ZERO;
         pat_r   <= {CHAIN_LEN{1'b0}};
         sh_r    <= {CHAIN_LEN{1'b0}};
         resp_r  <= {CHAIN_LEN{1'b0}};
         se_r    <= 1'b0;
         si_r    <= SI_FILL;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
`ifdef SCAN_COMPARE_EN
         exp_r   <= {CHAIN_LEN{1'b0}};
         pass_r  <= 1'b0;
`endif
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         pat_r   <= pat_s;
         sh_r    <= sh_s;
         resp_r  <= resp_s;
         se_r    <= se_s;
         si_r    <= si_s;
         busy_r  <= busy_s;
         done_r  <= done_s;
`ifdef SCAN_COMPARE_EN
         exp_r   <= exp_s;
         pass_r  <= pass_s;
`endif
      end
   end

   assign se       = se_r;
   assign si       = si_r;
   assign busy     = busy_r;
   assign done     = done_r;
   assign response = resp_r;
`ifdef SCAN_COMPARE_EN
   assign pass     = pass_r;
`endif

endmodule

// File: tb/tb_scan_test_controller.sv
// Bench for scan_test_controller with a four-stage SDFF chain attached and a
// cycle-index model of the test sequence; define SCAN_COMPARE_EN to cover PASS.
module tb_scan_test_controller;

   localparam int   N    = 4;
   localparam logic FILL = 1'b0;

   logic         clk = 1'b0;
   logic         rstn, start, abort, so, se, si, busy, done;
   logic [N-1:0] pattern, response, di;
   logic [N-1:0] chain = 4'b0000;
`ifdef SCAN_COMPARE_EN
   logic [N-1:0] expected;
   logic         pass;
`endif

   int tests = 0;
   int fails = 0;
   int done_seen = 0;

   scan_test_controller #(.CHAIN_LEN(N), .SI_FILL(FILL)) dut (
      .clk(clk), .rstn(rstn), .start(start), .abort(abort), .pattern(pattern),
`ifdef SCAN_COMPARE_EN
      .expected(expected), .pass(pass),
`endif
      .so(so), .se(se), .si(si), .busy(busy), .done(done), .response(response)
   );

   always #5 clk = ~clk;

   // Chain under test: shifts si in at stage 0 when se, else captures di.
   always @(posedge clk) begin
      if (se) chain <= {chain[N-2:0], si};
      else    chain <= di;
   end
   assign so = chain[N-1];

   task automatic chk1(input string name, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk4(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chki(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: m_t is the cycle index within a test (1..2N+1), 0 when idle.
   int           m_t;
   logic [N-1:0] m_p, m_cap, m_resp, m_exp;
   logic         m_done, m_pass;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_t <= 0; m_done <= 1'b0; m_resp <= 4'b0000; m_pass <= 1'b0;
      end else if (abort) begin
         m_t <= 0; m_done <= 1'b0;
      end else if (m_t == 0) begin
         m_done <= 1'b0;
         if (start) begin
            m_t <= 1; m_p <= pattern;
`ifdef SCAN_COMPARE_EN
            m_exp <= expected;
`endif
         end
      end else if (m_t == 2*N+1) begin
         m_t <= 0; m_done <= 1'b1; m_resp <= m_cap;
         m_pass <= (m_cap == m_exp);
      end else begin
         m_done <= 1'b0;
         m_t <= m_t + 1;
         if (m_t == N+1) m_cap <= di;
      end
   end

   // Compare process: every output against the model on every cycle out of reset.
   always @(negedge clk) begin
      if (rstn) begin
         automatic logic e_shift_in = (m_t >= 1 && m_t <= N);
         automatic logic e_se = e_shift_in || (m_t >= N+2 && m_t <= 2*N+1);
         automatic logic e_si = e_shift_in ? m_p[N-m_t] : FILL;
         chk1("se", se, e_se);
         chk1("si", si, e_si);
         chk1("busy", busy, (m_t != 0));
         chk1("done", done, m_done);
         chk4("response", response, m_resp);
`ifdef SCAN_COMPARE_EN
         chk1("pass", pass, m_pass);
`endif
         if (m_t == N+1) chk4("chain_load", chain, m_p);
         if (done) done_seen++;
      end
   end

   initial begin
      logic [N-1:0] si_got, se_got, resp_got;
      int done_c, d1, d2, ds;
      rstn = 1'b0; start = 1'b0; abort = 1'b0; pattern = 4'b0000; di = 4'b0000;
`ifdef SCAN_COMPARE_EN
      expected = 4'b0110;
`endif
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      chk1("rst_se", se, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_done", done, 1'b0);
      chk4("rst_response", response, 4'b0000);

      // Single test: pattern 1011, chain captures 0110.
      pattern = 4'b1011; di = 4'b0110; start = 1'b1;
      si_got = 4'b0000; se_got = 4'b0000; resp_got = 4'b0000; done_c = -1;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (c == 1) start = 1'b0;
         if (c <= 4) begin si_got[4-c] = si; se_got[4-c] = se; end
         if (c == 5) begin
            chk1("capture_se", se, 1'b0);
            chk4("chain_after_shift", chain, 4'b1011);
         end
         if (done && done_c < 0) begin
            done_c = c; resp_got = response;
`ifdef SCAN_COMPARE_EN
            chk1("pass_match", pass, 1'b1);
`endif
         end
      end
      chk4("si_sequence", si_got, 4'b1011);
      chk4("se_shift_in", se_got, 4'b1111);
      chki("done_cycle", done_c, 10);
      chk4("response_0110", resp_got, 4'b0110);

`ifdef SCAN_COMPARE_EN
      // Mismatching capture clears PASS.
      di = 4'b0111; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (9) @(negedge clk);
      chk1("done_mismatch", done, 1'b1);
      chk1("pass_mismatch", pass, 1'b0);
`endif

      // START held high: back-to-back tests, DONE in cycles 10 and 20.
      di = 4'b0110; pattern = 4'b0101; start = 1'b1; d1 = -1; d2 = -1; ds = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (done) begin
            ds++;
            if (d1 < 0) d1 = c; else d2 = c;
         end
         if (c == 20) start = 1'b0;
      end
      chki("held_done1", d1, 10);
      chki("held_done2", d2, 20);
      chki("held_done_count", ds, 2);
      repeat (2) @(negedge clk);

      // ABORT in cycle 6: idle in cycle 7, no DONE, response retained.
      pattern = 4'b1100; di = 4'b1001; start = 1'b1; ds = done_seen;
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         if (c == 1) start = 1'b0;
         if (c == 6) abort = 1'b1;
         if (c == 7) begin
            abort = 1'b0;
            chk1("abort_busy", busy, 1'b0);
            chk1("abort_se", se, 1'b0);
         end
      end
      repeat (12) @(negedge clk);
      chki("abort_no_done", done_seen, ds);
      chk4("abort_response_kept", response, 4'b0110);

      // START and ABORT on the same edge: stays idle.
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      chk1("start_abort_busy", busy, 1'b0);
      @(negedge clk);
      chk1("start_abort_idle", busy, 1'b0);

      // Randomized traffic against the model.
      repeat (400) begin
         @(negedge clk);
         start   = ($urandom_range(0, 9) < 3);
         abort   = ($urandom_range(0, 99) < 3);
         pattern = 4'($urandom);
         di      = 4'($urandom);
`ifdef SCAN_COMPARE_EN
         expected = ($urandom_range(0, 1) == 0) ? di : 4'($urandom);
`endif
      end
      start = 1'b0; abort = 1'b0;
      repeat (25) @(negedge clk);

      // Reset in the middle of shift-out.
      pattern = 4'b1110; di = 4'b1011; start = 1'b1;
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         if (c == 1) start = 1'b0;
      end
      rstn = 1'b0;
      #1;
      chk1("midrst_se", se, 1'b0);
      chk1("midrst_busy", busy, 1'b0);
      chk1("midrst_done", done, 1'b0);
      chk4("midrst_response", response, 4'b0000);
      @(negedge clk);
      rstn = 1'b1; ds = done_seen;
      repeat (12) @(negedge clk);
      chki("midrst_no_done", done_seen, ds);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
